mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of the EX-stage ALU. Consumes the ALU result as load/store
//  address (or as a pass-through result), issues one data-memory request per load/store over a
//  req/gnt + rvalid handshake, aligns store data/strobes and sign/zero-extends load data, then
//  presents a registered result to writeback. Stalls EX while a memory access is outstanding.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles spent in REQ+WAIT before abort with bus error; 0 disables timeout
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  ex_valid       in   1   EX presents an instruction this cycle
//  ex_ready       out  1   stage accepts; transfer when ex_valid && ex_ready
//  ex_alu_out     in   32  ALU result: address for ld/st, else result to write back
//  ex_rs2_data    in   32  store data (forwarded)
//  ex_mem_read    in   1   load instruction
//  ex_mem_write   in   1   store instruction (never both with mem_read)
//  ex_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_rd          in   5   destination register
//  ex_reg_write   in   1   instruction writes rd
//  dm_req         out  1   memory request, held until dm_gnt
//  dm_we          out  1   1 = write
//  dm_addr        out  32  word-aligned address ({addr[31:2],2'b00})
//  dm_wdata       out  32  lane-aligned store data
//  dm_wstrb       out  4   active-high byte strobes
//  dm_gnt         in   1   request accepted this cycle
//  dm_rvalid      in   1   read data valid (only after a granted read)
//  dm_rdata       in   32  read word
//  wb_valid       out  1   one-cycle pulse: result for WB
//  wb_data        out  32  writeback value
//  wb_rd          out  5   destination register
//  wb_reg_write   out  1   write enable (0 if rd==0, misaligned or bus error)
//  wb_misalign    out  1   with wb_valid: misaligned access, no memory request made
//  wb_bus_err     out  1   with wb_valid: timeout abort
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, except ex_ready=1. Reset mid-access drops dm_req at once.
//  - FSM IDLE/REQ/WAIT. ex_ready = (state==IDLE); REQ/WAIT stall EX. WB has no backpressure.
//  - IDLE, accepted non-memory op: wb_valid next cycle, wb_data=ex_alu_out. Latency 1.
//  - IDLE, accepted ld/st, aligned: capture fields, -> REQ; dm_* driven from registers.
//  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): no dm_req, stay IDLE; wb_valid next
//    cycle with wb_misalign=1, wb_reg_write=0.
//  - REQ: dm_req=1 until dm_gnt. Store + gnt -> IDLE, wb_valid next cycle, wb_reg_write=0.
//    Load + gnt -> WAIT (dm_req low). rvalid in the gnt cycle is ignored.
//  - WAIT: on dm_rvalid -> IDLE, wb_valid next cycle with extracted data.
//  - Store: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}},
//    wstrb = addr[1] ? 4'b1100 : 4'b0011; SW wdata=rs2, wstrb=4'b1111.
//  - Load: select byte addr[1:0] / half addr[1]; B,H sign-extend; BU,HU zero-extend; W as-is.
//  - Timeout: counter clears on entering REQ and counts in REQ+WAIT. At TIMEOUT_CYC: -> IDLE,
//    dm_req drops, wb_valid with wb_bus_err=1, wb_reg_write=0. A late rvalid is ignored in IDLE.
//  - wb_* hold their last value when wb_valid=0; wb_misalign and wb_bus_err are 0 when
//    wb_valid=0. Exactly one outstanding access; no new accept in the cycle wb_valid pulses
//    after a memory op unless the state is IDLE.
// TESTING
//  - ALU op 0x1234_5678, rd=5 -> wb_valid next cycle, wb_data=0x12345678, wb_reg_write=1.
//  - SB addr 0x103, rs2=0xAB -> dm_addr=0x100, wstrb=1000, wdata=0xABABABAB; gnt after 3 stall
//    cycles -> ex_ready low 3 cycles, then wb_reg_write=0.
//  - LB addr 0x101, rdata=0x0000_8000 -> wb_data=0xFFFFFF80. LBU same -> 0x00000080.
//    LH addr 0x102, rdata=0x8001_0000 -> wb_data=0xFFFF8001.
//  - LW addr 0x102 -> no dm_req; wb_misalign=1, wb_reg_write=0 next cycle.
//  - Load never answered, TIMEOUT_CYC=16 -> wb_bus_err pulse after 16 cycles; later rvalid ignored.
//  - rst_n low while in WAIT -> dm_req=0, ex_ready=1 immediately; wb_valid=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage behind the EX-stage ALU. Non-memory ops pass their ALU
//   result straight to writeback with one cycle of latency. Loads and stores
//   issue a single data-memory request over a req/gnt + rvalid handshake.
//   Store data and strobes are lane-aligned, and load data is sign- or
//   zero-extended. EX is stalled while an access is outstanding. A watchdog
//   aborts an access that takes too long and reports it as a bus error.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ex_*              instruction from EX, valid/ready handshake
//   dm_*              data-memory request/grant/response interface
//   wb_*              registered one-cycle result pulse toward writeback
//
// Parameter
//   TIMEOUT_CYC       cycles allowed in REQ+WAIT before abort; 0 = never
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;

  // Captured access
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [31:0] to_cnt;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        timeout;
  logic        capture;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Next writeback contents, applied when wb_set
  logic        wb_set;
  logic [31:0] nx_data;
  logic [4:0]  nx_rd;
  logic        nx_rw;
  logic        nx_mis;
  logic        nx_err;

  assign ex_ready = (state == S_IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_mem_read || ex_mem_write;
  assign timeout  = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);

  assign dm_req   = (state == S_REQ);
  assign dm_we    = r_we;
  assign dm_addr  = {r_addr[31:2], 2'b00};
  assign dm_wdata = r_wdata;
  assign dm_wstrb = r_wstrb;

  // Size from funct3[1:0]: 00 byte, 01 half, otherwise word
  always_comb begin
    misaligned = 1'b0;
    st_wdata   = ex_rs2_data;
    st_wstrb   = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << ex_alu_out[1:0];
      end
      2'b01: begin
        misaligned = ex_alu_out[0];
        st_wdata   = {2{ex_rs2_data[15:0]}};
        st_wstrb   = ex_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = (ex_alu_out[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // A completing handshake wins over a timeout in the same cycle; a load
  // granted in its final allowed cycle is still aborted.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    wb_set   = 1'b0;
    nx_data  = '0;
    nx_rd    = '0;
    nx_rw    = 1'b0;
    nx_mis   = 1'b0;
    nx_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_set  = 1'b1;
            nx_data = ex_alu_out;
            nx_rd   = ex_rd;
            nx_rw   = ex_reg_write && (ex_rd != 5'd0);
          end else if (misaligned) begin
            wb_set  = 1'b1;
            nx_data = ex_alu_out;
            nx_rd   = ex_rd;
            nx_mis  = 1'b1;
          end else begin
            capture  = 1'b1;
            state_nx = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm_gnt && r_we) begin
          state_nx = S_IDLE;
          wb_set   = 1'b1;
          nx_data  = r_addr;
          nx_rd    = r_rd;
        end else if (timeout) begin
          state_nx = S_IDLE;
          wb_set   = 1'b1;
          nx_data  = r_addr;
          nx_rd    = r_rd;
          nx_err   = 1'b1;
        end else if (dm_gnt) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dm_rvalid) begin
          state_nx = S_IDLE;
          wb_set   = 1'b1;
          nx_data  = ld_data;
          nx_rd    = r_rd;
          nx_rw    = r_reg_write && (r_rd != 5'd0);
        end else if (timeout) begin
          state_nx = S_IDLE;
          wb_set   = 1'b1;
          nx_data  = r_addr;
          nx_rd    = r_rd;
          nx_err   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      to_cnt      <= '0;
    end else begin
      if (capture) begin
        r_addr      <= ex_alu_out;
        r_wdata     <= ex_mem_write ? st_wdata : '0;
        r_wstrb     <= ex_mem_write ? st_wstrb : '0;
        r_we        <= ex_mem_write;
        r_funct3    <= ex_funct3;
        r_rd        <= ex_rd;
        r_reg_write <= ex_reg_write;
      end
      if (capture)               to_cnt <= '0;
      else if (state != S_IDLE)  to_cnt <= to_cnt + 32'd1;
    end
  end

  // Payload holds between pulses; the status flags only accompany a pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
      wb_bus_err   <= 1'b0;
    end else begin
      wb_valid    <= wb_set;
      wb_misalign <= wb_set && nx_mis;
      wb_bus_err  <= wb_set && nx_err;
      if (wb_set) begin
        wb_data      <= nx_data;
        wb_rd        <= nx_rd;
        wb_reg_write <= nx_rw;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: scoreboard of expected writeback results,
// popped whenever the DUT pulses wb_valid.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misalign;
  logic        wb_bus_err;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mem_access_stage #(.TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_alu_out   (ex_alu_out),
    .ex_rs2_data  (ex_rs2_data),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_wstrb     (dm_wstrb),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_misalign  (wb_misalign),
    .wb_bus_err   (wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a[1:0];
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> {a[1:0], 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_data) check_eq("wb_data", wb_data, e.data);
        check_eq("wb_rd", 32'(wb_rd), 32'(e.rd));
        check_eq("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        check_eq("wb_misalign", 32'(wb_misalign), 32'(e.mis));
        check_eq("wb_bus_err", 32'(wb_bus_err), 32'(e.err));
      end
    end else if (rst_n && (wb_misalign || wb_bus_err)) begin
      check_eq("wb_flags_idle", {30'd0, wb_misalign, wb_bus_err}, 32'd0);
    end
  end

  task automatic clear_ex();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_reg_write = 1'b0; ex_funct3 = 3'b000;
  endtask

  task automatic drive_ex(input logic [31:0] a, input logic [31:0] rs2, input logic rd_op,
                          input logic wr_op, input logic [2:0] f3, input logic [4:0] rd, input logic rw);
    ex_valid = 1'b1; ex_alu_out = a; ex_rs2_data = rs2; ex_mem_read = rd_op;
    ex_mem_write = wr_op; ex_funct3 = f3; ex_rd = rd; ex_reg_write = rw;
  endtask

  // Called 1 time unit after a rising edge with the DUT idle
  task automatic alu_op(input logic [31:0] v, input logic [4:0] rd, input logic rw);
    exp_t e;
    e.data = v; e.chk_data = 1'b1; e.rd = rd; e.rw = rw && (rd != 5'd0); e.mis = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    drive_ex(v, 32'h0, 1'b0, 1'b0, 3'b000, rd, rw);
    @(posedge clk); #1;
    clear_ex();
    check_eq("alu_latency", 32'(wb_valid), 32'd1);
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic st, input logic [4:0] rd, input logic rw,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        output int stalls);
    exp_t e;
    stalls = 0;
    e.data = '0; e.chk_data = 1'b0; e.rd = rd; e.rw = 1'b0; e.mis = 1'b0; e.err = 1'b0;
    drive_ex(addr, rs2, !st, st, f3, rd, rw);
    if (is_mis(f3, addr)) begin
      e.mis = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      clear_ex();
      check_eq("mis_no_req", 32'(dm_req), 32'd0);
      check_eq("mis_ready", 32'(ex_ready), 32'd1);
      return;
    end
    @(posedge clk); #1;
    clear_ex();
    check_eq("dm_req", 32'(dm_req), 32'd1);
    check_eq("dm_we", 32'(dm_we), 32'(st));
    check_eq("dm_addr", dm_addr, {addr[31:2], 2'b00});
    if (st) begin
      check_eq("dm_wstrb", 32'(dm_wstrb), 32'(st_strb(f3, addr)));
      check_eq("dm_wdata", dm_wdata, st_data(f3, rs2));
    end
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk); if (!ex_ready) stalls++;
      @(posedge clk); #1;
    end
    dm_gnt = 1'b1;
    if (st) exp_q.push_back(e);
    else begin
      dm_rvalid = 1'b1;            // must be ignored in the grant cycle
      dm_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk); if (!ex_ready) stalls++;
    @(posedge clk); #1;
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    if (!st) begin
      check_eq("ld_req_low", 32'(dm_req), 32'd0);
      for (int i = 0; i < rv_wait; i++) begin
        @(negedge clk); if (!ex_ready) stalls++;
        @(posedge clk); #1;
      end
      e.data = ld_ext(f3, addr, rdata); e.chk_data = 1'b1; e.rw = rw && (rd != 5'd0);
      exp_q.push_back(e);
      dm_rvalid = 1'b1; dm_rdata = rdata;
      @(negedge clk); if (!ex_ready) stalls++;
      @(posedge clk); #1;
      dm_rvalid = 1'b0; dm_rdata = $urandom;
    end
    check_eq("wb_pulse", 32'(wb_valid), 32'd1);
  endtask

  // Accept a load or store and never complete it; returns cycles to the abort pulse
  task automatic timeout_op(input logic st, input logic gnt_first, input logic [4:0] rd, output int cyc);
    exp_t e;
    e.data = '0; e.chk_data = 1'b0; e.rd = rd; e.rw = 1'b0; e.mis = 1'b0; e.err = 1'b1;
    exp_q.push_back(e);
    drive_ex(32'h0000_0200, 32'h1111_2222, !st, st, 3'b010, rd, !st);
    @(posedge clk); #1;
    clear_ex();
    dm_gnt = gnt_first;
    cyc = 0;
    while (!wb_valid && cyc < 40) begin
      @(posedge clk); #1;
      dm_gnt = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int stalls;
    int cyc;
    logic [2:0] f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    rst_n = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    ex_alu_out = '0; ex_rs2_data = '0; ex_rd = '0;
    clear_ex();
    #3;
    check_eq("rst_ex_ready", 32'(ex_ready), 32'd1);
    check_eq("rst_dm_req", 32'(dm_req), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_dm_wstrb", 32'(dm_wstrb), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through ops, including rd=0 and back-to-back accepts
    alu_op(32'h1234_5678, 5'd5, 1'b1);
    check_eq("alu_wb_data_direct", wb_data, 32'h1234_5678);
    alu_op(32'hCAFE_0001, 5'd0, 1'b1);
    alu_op(32'h0000_00FF, 5'd9, 1'b0);
    @(posedge clk); #1;
    check_eq("wb_drop", 32'(wb_valid), 32'd0);
    check_eq("wb_hold", wb_data, 32'h0000_00FF);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = 32'hA000_0000 + 32'(i); e.chk_data = 1'b1; e.rd = 5'(i + 1);
      e.rw = 1'b1; e.mis = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
      drive_ex(e.data, 32'h0, 1'b0, 1'b0, 3'b000, e.rd, 1'b1);
      @(posedge clk); #1;
    end
    clear_ex();
    @(posedge clk); #1;

    // SB 0x103 granted on the third REQ cycle
    mem_op(32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b1, 5'd7, 1'b0, 2, 0, 32'h0, stalls);
    check_eq("sb_stalls", 32'(stalls), 32'd3);
    // Spec load vectors
    mem_op(32'h0000_0101, 32'h0, 3'b000, 1'b0, 5'd3, 1'b1, 0, 1, 32'h0000_8000, stalls);
    mem_op(32'h0000_0101, 32'h0, 3'b100, 1'b0, 5'd3, 1'b1, 1, 0, 32'h0000_8000, stalls);
    mem_op(32'h0000_0102, 32'h0, 3'b001, 1'b0, 5'd4, 1'b1, 0, 0, 32'h8001_0000, stalls);
    mem_op(32'h0000_0100, 32'h0, 3'b010, 1'b0, 5'd0, 1'b1, 0, 2, 32'h8765_4321, stalls);
    // Misaligned LW and SH
    mem_op(32'h0000_0102, 32'h0, 3'b010, 1'b0, 5'd6, 1'b1, 0, 0, 32'h0, stalls);
    @(posedge clk); #1;
    check_eq("mis_still_no_req", 32'(dm_req), 32'd0);
    mem_op(32'h0000_0105, 32'h5555, 3'b001, 1'b1, 5'd6, 1'b0, 0, 0, 32'h0, stalls);
    // SH upper half and SW
    mem_op(32'h0000_0302, 32'h1234_BEEF, 3'b001, 1'b1, 5'd1, 1'b0, 1, 0, 32'h0, stalls);
    mem_op(32'h0000_0304, 32'h1234_BEEF, 3'b010, 1'b1, 5'd1, 1'b0, 0, 0, 32'h0, stalls);

    // Random mix of loads/stores across all offsets
    for (int i = 0; i < 12; i++) begin
      logic [2:0] f3;
      logic       st;
      f3 = f3_tab[$urandom_range(0, 4)];
      st = (f3[2] == 1'b0) && ($urandom_range(0, 1) == 1);
      mem_op(32'h0000_0400 + 32'($urandom_range(0, 15)), $urandom, f3, st,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, stalls);
    end

    // Load granted but never answered, then a late rvalid
    timeout_op(1'b0, 1'b1, 5'd12, cyc);
    check_eq("to_load_cycles", 32'(cyc), 32'd16);
    dm_rvalid = 1'b1; dm_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    check_eq("late_rvalid_ignored", 32'(wb_valid), 32'd0);
    check_eq("late_rvalid_ready", 32'(ex_ready), 32'd1);
    // Store never granted
    timeout_op(1'b1, 1'b0, 5'd13, cyc);
    check_eq("to_store_cycles", 32'(cyc), 32'd16);
    check_eq("to_store_req_drop", 32'(dm_req), 32'd0);

    // Reset while in REQ: dm_req drops without a clock edge
    drive_ex(32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd2, 1'b1);
    @(posedge clk); #1;
    clear_ex();
    check_eq("pre_rst_req", 32'(dm_req), 32'd1);
    #2 rst_n = 1'b0; #1;
    check_eq("rst_req_dm_req", 32'(dm_req), 32'd0);
    check_eq("rst_req_ready", 32'(ex_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset while in WAIT
    drive_ex(32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd2, 1'b1);
    @(posedge clk); #1;
    clear_ex();
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    check_eq("wait_stall", 32'(ex_ready), 32'd0);
    #2 rst_n = 1'b0; #1;
    check_eq("rst_wait_dm_req", 32'(dm_req), 32'd0);
    check_eq("rst_wait_ready", 32'(ex_ready), 32'd1);
    check_eq("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op(32'h7777_0000, 5'd31, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
